cdb_broadcaster: RTL and testbench
==================================

// Module: cdb_broadcaster
// PURPOSE
//  Result-side writer for the tagged register bank on the common data bus (CDB).
//  Arbitrates completed results from the functional units, one broadcast per cycle.
//  Each broadcast drives tag+data onto the CDB. It also raises registered, glitch-free
//  DataControl/LabelControl pulses for every register whose current label equals the tag.
//  Sits between the functional-unit outputs and the register bank's write/label ports.
// PARAMETERS
//  N_REQ   2       number of requesting functional units
//  N_REG   3       number of tagged registers driven
//  W       9       tag and data width
//  NO_TAG  9'h1FF  label value meaning "no pending producer"
// PORTS
//  clk            in   1          clock, all state on rising edge
//  rst_n          in   1          synchronous, active-low reset
//  req_valid      in   N_REQ      unit i holds a result
//  req_tag        in   N_REQ*W    tag of unit i, slice [i*W +: W]
//  req_data       in   N_REQ*W    result of unit i, slice [i*W +: W]
//  req_ready      out  N_REQ      unit i granted this cycle (result consumed)
//  reg_label      in   N_REG*W    current label of register j
//  issue_we       in   N_REG      issue stage renames register j this cycle
//  cdb_valid      out  1          broadcast present
//  cdb_tag        out  W          broadcast tag
//  cdb_data       out  W          broadcast data, also register write data
//  reg_data_we    out  N_REG      DataControl pulse to register j
//  reg_label_clr  out  N_REG      LabelControl pulse to register j (label input = NO_TAG)
//  bad_tag        out  1          sticky: a request carried NO_TAG
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): cdb_valid=0, cdb_tag=NO_TAG, cdb_data=0, reg_data_we=0,
//    reg_label_clr=0, bad_tag=0, rr_ptr=0. req_ready is forced 0 while rst_n=0.
//    An in-flight broadcast is dropped.
//  - Arbitration (combinational, cycle t): round-robin over the valid units, starting at rr_ptr.
//    The winner w gets req_ready[w]=1. All others get 0. No valid unit: no grant.
//  - match[j] = (reg_label[j] == req_tag[w]), evaluated in cycle t.
//  - Stall: no grant in cycle t if (match & reg_data_we) != 0. This guarantees a low cycle
//    between pulses to the same register, because the registers are edge-triggered. With no
//    grant, rr_ptr holds.
//  - Grant with tag != NO_TAG, registered at the end of t, visible in t+1:
//      cdb_valid=1, cdb_tag/cdb_data = winner values,
//      reg_data_we = match & ~issue_we, reg_label_clr = match & ~issue_we,
//      rr_ptr = (w+1) mod N_REQ.
//  - Grant with tag == NO_TAG: consumed (req_ready=1), bad_tag<=1, no broadcast in t+1,
//    rr_ptr advances.
//  - No grant: t+1 has cdb_valid=0 and all pulses 0. cdb_tag/cdb_data hold their last values.
//  - Every pulse is exactly 1 cycle. Latency from grant to broadcast is 1 cycle.
//    Throughput is 1 broadcast per cycle.
//  - A tag matching no register still broadcasts, with all pulses 0.
//  - issue_we[j] in the grant cycle suppresses both pulses for j: the newer rename wins.
// TESTING
//  1. Reset, req0 valid, tag=005, data=0AB, reg_label1=005 -> req_ready=01 same cycle;
//     next cycle cdb_valid=1, tag=005, data=0AB, we=clr=3'b010; all 0 the cycle after.
//  2. Both units valid continuously, tags 010/011 -> grants 0,1,0,1 after reset; cdb_tag
//     alternates 010/011 every cycle.
//  3. Tag 007 with reg_label0=reg_label2=007 -> we=clr=3'b101 for one cycle.
//  4. As test 3 with issue_we=3'b100 in the grant cycle -> we=clr=3'b001.
//  5. req0 tag 00A matches reg0; next cycle req1 tag 00B, reg_label0 now 00B ->
//     req1 stalled 1 cycle; we[0] pulses high, low, high.
//  6. req0 tag 1FF -> req_ready0=1, cdb_valid stays 0, bad_tag=1 held until rst_n=0;
//     rst_n=0 mid-broadcast -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// Common-data-bus writer: round-robin pick of one completed result per cycle,
// registered broadcast plus one-cycle data/label pulses to every register waiting on the tag.
module cdb_broadcaster #(
    parameter int             N_REQ  = 2,
    parameter int             N_REG  = 3,
    parameter int             W      = 9,
    parameter logic [W-1:0]   NO_TAG = 9'h1FF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_tag,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REG*W-1:0]   reg_label,
    input  logic [N_REG-1:0]     issue_we,
    output logic                 cdb_valid,
    output logic [W-1:0]         cdb_tag,
    output logic [W-1:0]         cdb_data,
    output logic [N_REG-1:0]     reg_data_we,
    output logic [N_REG-1:0]     reg_label_clr,
    output logic                 bad_tag
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    rrPtr_r;
    logic [PW-1:0]    winIdx_s;
    logic [PW-1:0]    cand_s;
    logic [PW-1:0]    nextPtr_s;
    logic             anyValid_s;
    logic             hit_s;
    logic             stall_s;
    logic             grant_s;
    logic             noTag_s;
    logic [W-1:0]     winTag_s;
    logic [W-1:0]     winData_s;
    logic [N_REG-1:0] match_s;

    // Round-robin winner search, first valid unit at or after rrPtr_r
    always_comb begin
        anyValid_s = 1'b0;
        winIdx_s   = '0;
        cand_s     = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s     = PW'((int'(rrPtr_r) + k) % N_REQ);
            hit_s      = req_valid[cand_s] & ~anyValid_s;
            winIdx_s   = hit_s ? cand_s : winIdx_s;
            anyValid_s = anyValid_s | hit_s;
        end
    end

    // Tag compare against every register label, stall and grant decision
    always_comb begin
        winTag_s  = req_tag[int'(winIdx_s) * W +: W];
        winData_s = req_data[int'(winIdx_s) * W +: W];
        match_s   = '0;
        for (int j = 0; j < N_REG; j++) begin
            match_s[j] = (reg_label[j * W +: W] == winTag_s);
        end
        // A register pulsed this cycle must see a low cycle before its next pulse.
        stall_s   = |(match_s & reg_data_we);
        grant_s   = rst_n & anyValid_s & ~stall_s;
        noTag_s   = (winTag_s == NO_TAG);
        nextPtr_s = (winIdx_s == PW'(N_REQ - 1)) ? '0 : winIdx_s + PW'(1);
    end

    // One-hot grant back to the winning unit
    always_comb begin
        req_ready           = '0;
        req_ready[winIdx_s] = grant_s;
    end

    // Broadcast, pulse and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= NO_TAG;
            cdb_data      <= '0;
            reg_data_we   <= '0;
            reg_label_clr <= '0;
            bad_tag       <= 1'b0;
            rrPtr_r       <= '0;
        end else begin
            if (grant_s && !noTag_s) begin
                cdb_valid     <= 1'b1;
                cdb_tag       <= winTag_s;
                cdb_data      <= winData_s;
                // A same-cycle rename means the register now waits on a newer producer.
                reg_data_we   <= match_s & ~issue_we;
                reg_label_clr <= match_s & ~issue_we;
            end else begin
                cdb_valid     <= 1'b0;
                reg_data_we   <= '0;
                reg_label_clr <= '0;
            end
            if (grant_s) begin
                rrPtr_r <= nextPtr_s;
            end else begin
                rrPtr_r <= rrPtr_r;
            end
            if (grant_s && noTag_s) begin
                bad_tag <= 1'b1;
            end else begin
                bad_tag <= bad_tag;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration and pulse rules.
module tb_cdb_broadcaster;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [17:0] req_tag;
    logic [17:0] req_data;
    logic [1:0]  req_ready;
    logic [26:0] reg_label;
    logic [2:0]  issue_we;
    logic        cdb_valid;
    logic [8:0]  cdb_tag;
    logic [8:0]  cdb_data;
    logic [2:0]  reg_data_we;
    logic [2:0]  reg_label_clr;
    logic        bad_tag;

    int checks = 0;
    int errors = 0;

    cdb_broadcaster dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
        .req_data(req_data), .req_ready(req_ready), .reg_label(reg_label),
        .issue_we(issue_we), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .reg_data_we(reg_data_we), .reg_label_clr(reg_label_clr),
        .bad_tag(bad_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 2'b00; issue_we = 3'b000;
        reg_label = 27'd0; req_tag = 18'd0; req_data = 18'd0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [8:0] pick_tag();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? 9'h1FF : 9'h020 + 9'(r % 4);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; req_tag = {9'h011, 9'h010};
        tick();
        tick();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
        checks++; if ({cdb_valid, cdb_tag, cdb_data} !== {1'b0, 9'h1FF, 9'h000}) begin errors++; $display("FAIL reset_cdb got v=%b t=%h d=%h exp v=0 t=1ff d=000", cdb_valid, cdb_tag, cdb_data); end
        checks++; if ({reg_data_we, reg_label_clr, bad_tag} !== 7'd0) begin errors++; $display("FAIL reset_pulses got we=%b clr=%b bad=%b exp 0", reg_data_we, reg_label_clr, bad_tag); end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01; req_tag = {9'h000, 9'h005}; req_data = {9'h000, 9'h0AB};
        reg_label = {9'h000, 9'h005, 9'h000};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 9'h005, 9'h0AB}) begin errors++; $display("FAIL single_bcast got v=%b t=%h d=%h exp v=1 t=005 d=0ab", cdb_valid, cdb_tag, cdb_data); end
        checks++; if ({reg_data_we, reg_label_clr} !== 6'b010_010) begin errors++; $display("FAIL single_pulse got we=%b clr=%b exp 010/010", reg_data_we, reg_label_clr); end
        tick();
        #1;
        checks++; if ({cdb_valid, reg_data_we, reg_label_clr} !== 7'd0) begin errors++; $display("FAIL single_after got v=%b we=%b clr=%b exp 0", cdb_valid, reg_data_we, reg_label_clr); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] expR;
        logic [8:0] expT;
        do_reset();
        req_valid = 2'b11; req_tag = {9'h011, 9'h010}; req_data = {9'h022, 9'h021};
        for (int i = 0; i < 5; i++) begin
            #1;
            expR = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_ready !== expR) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", i, req_ready, expR); end
            if (i > 0) begin
                expT = ((i - 1) % 2 == 0) ? 9'h010 : 9'h011;
                checks++; if ({cdb_valid, cdb_tag} !== {1'b1, expT}) begin errors++; $display("FAIL b2b_tag cyc %0d got v=%b t=%h exp v=1 t=%h", i, cdb_valid, cdb_tag, expT); end
            end
            tick();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_multi_match(input logic [2:0] iw, input logic [2:0] expP);
        do_reset();
        req_valid = 2'b01; req_tag = {9'h000, 9'h007}; req_data = {9'h000, 9'h099};
        reg_label = {9'h007, 9'h000, 9'h007}; issue_we = iw;
        tick();
        req_valid = 2'b00; issue_we = 3'b000;
        #1;
        checks++; if ({reg_data_we, reg_label_clr} !== {expP, expP}) begin errors++; $display("FAIL multi iw=%b got we=%b clr=%b exp %b", iw, reg_data_we, reg_label_clr, expP); end
        tick();
        #1;
        checks++; if ({reg_data_we, reg_label_clr} !== 6'd0) begin errors++; $display("FAIL multi_after got we=%b clr=%b exp 0", reg_data_we, reg_label_clr); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 2'b01; req_tag = {9'h000, 9'h00A}; reg_label = {9'h000, 9'h000, 9'h00A};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_g0 got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b10; req_tag = {9'h00B, 9'h000}; reg_label = {9'h000, 9'h000, 9'h00B};
        #1;
        checks++; if ({req_ready, reg_data_we[0]} !== 3'b001) begin errors++; $display("FAIL stall_hold got ready=%b we0=%b exp 00/1", req_ready, reg_data_we[0]); end
        tick();
        #1;
        checks++; if ({req_ready, reg_data_we[0]} !== 3'b100) begin errors++; $display("FAIL stall_release got ready=%b we0=%b exp 10/0", req_ready, reg_data_we[0]); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if ({reg_data_we[0], cdb_tag} !== {1'b1, 9'h00B}) begin errors++; $display("FAIL stall_second got we0=%b t=%h exp 1/00b", reg_data_we[0], cdb_tag); end
    endtask

    task automatic test_bad_tag();
        do_reset();
        req_valid = 2'b01; req_tag = {9'h000, 9'h1FF};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bad_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if ({cdb_valid, bad_tag} !== 2'b01) begin errors++; $display("FAIL bad_flag got v=%b bad=%b exp 0/1", cdb_valid, bad_tag); end
        tick();
        req_valid = 2'b10; req_tag = {9'h0C3, 9'h000}; req_data = {9'h055, 9'h000};
        reg_label = {9'h000, 9'h0C3, 9'h000};
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if ({cdb_valid, reg_data_we, bad_tag} !== {1'b1, 3'b010, 1'b1}) begin errors++; $display("FAIL bad_sticky got v=%b we=%b bad=%b exp 1/010/1", cdb_valid, reg_data_we, bad_tag); end
        rst_n = 1'b0;
        tick();
        #1;
        checks++; if ({cdb_valid, cdb_tag, cdb_data, reg_data_we, reg_label_clr, bad_tag} !== {1'b0, 9'h1FF, 9'h000, 3'b000, 3'b000, 1'b0}) begin errors++; $display("FAIL bad_midreset got v=%b t=%h d=%h we=%b clr=%b bad=%b exp reset values", cdb_valid, cdb_tag, cdb_data, reg_data_we, reg_label_clr, bad_tag); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int mPtr, win, u;
        logic mValid, mBad, stall, granted;
        logic [8:0] mTag, mData, wTag;
        logic [2:0] mWe, mt;
        logic [1:0] expR;
        do_reset();
        mPtr = 0; mValid = 1'b0; mBad = 1'b0; mTag = 9'h1FF; mData = 9'h000; mWe = 3'b000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            req_valid = 2'($urandom_range(0, 3));
            for (int q = 0; q < 2; q++) begin
                req_tag[q*9 +: 9]  = pick_tag();
                req_data[q*9 +: 9] = 9'($urandom_range(0, 511));
            end
            for (int j = 0; j < 3; j++) reg_label[j*9 +: 9] = pick_tag();
            issue_we = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            #1;
            checks++; if ({cdb_valid, reg_data_we, reg_label_clr, bad_tag} !== {mValid, mWe, mWe, mBad}) begin errors++; $display("FAIL rnd_ctrl cyc %0d got v=%b we=%b clr=%b bad=%b exp v=%b we=%b bad=%b", cyc, cdb_valid, reg_data_we, reg_label_clr, bad_tag, mValid, mWe, mBad); end
            checks++; if ({cdb_tag, cdb_data} !== {mTag, mData}) begin errors++; $display("FAIL rnd_bus cyc %0d got t=%h d=%h exp t=%h d=%h", cyc, cdb_tag, cdb_data, mTag, mData); end
            win = -1;
            for (int k = 0; k < 2; k++) begin
                u = (mPtr + k) % 2;
                if (win < 0 && req_valid[u]) win = u;
            end
            mt = 3'b000; stall = 1'b0; granted = 1'b0; expR = 2'b00; wTag = 9'h000;
            if (win >= 0) begin
                wTag = req_tag[win*9 +: 9];
                for (int j = 0; j < 3; j++) mt[j] = (reg_label[j*9 +: 9] == wTag);
                stall   = |(mt & mWe);
                granted = rst_n && !stall;
            end
            if (granted) expR[win] = 1'b1;
            checks++; if (req_ready !== expR) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, expR); end
            if (!rst_n) begin
                mPtr = 0; mValid = 1'b0; mBad = 1'b0; mTag = 9'h1FF; mData = 9'h000; mWe = 3'b000;
            end else if (granted) begin
                mPtr = (win + 1) % 2;
                if (wTag == 9'h1FF) begin
                    mBad = 1'b1; mValid = 1'b0; mWe = 3'b000;
                end else begin
                    mValid = 1'b1; mTag = wTag; mData = req_data[win*9 +: 9]; mWe = mt & ~issue_we;
                end
            end else begin
                mValid = 1'b0; mWe = 3'b000;
            end
            tick();
        end
        rst_n = 1'b1; req_valid = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_tag = 18'd0; req_data = 18'd0;
        reg_label = 27'd0; issue_we = 3'b000;
        test_reset();
        test_single();
        test_back_to_back();
        test_multi_match(3'b000, 3'b101);
        test_multi_match(3'b100, 3'b001);
        test_stall();
        test_bad_tag();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
